fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline: owns the PC register, issues word fetches to instruction memory over a req/gnt/rvalid handshake, and presents PCF/InstrF/ValidF to the IF/ID pipeline register. It absorbs hazard-unit stalls through a one-entry skid buffer. Taken branches and jumps resolved in EX redirect it, which flushes every in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on InstrF when ValidF=0 (addi x0,x0,0)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- stall_f  in  1  hazard unit: IF/ID will not capture this edge
- redirect_e  in  1  taken branch/jump from EX
- redirect_pc_e  in  32  target; bits [1:0] ignored (forced 00)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- PCF  out  32  PC of presented instruction (to IF/ID PCD)
- InstrF  out  32  presented instruction (to IF/ID InstrD)
- PCPlus4F  out  32  PCF+4, combinational, wraps mod 2^32
- ValidF  out  1  PCF/InstrF hold a real instruction

## Operation
- State: pc_reg (next fetch address), fetch_pc (address of the outstanding request), kill flag, FSM {REQ, WAIT}, output entry (PCF/InstrF/ValidF), skid entry (pc, instr, valid).
- One outstanding request maximum.
- REQ: imem_req=1 when skid invalid and (ValidF=0 or stall_f=0); imem_addr=pc_reg always.
  - On gnt: fetch_pc<=pc_reg, pc_reg<=pc_reg+4 (32-bit wrap), go WAIT.
- WAIT: imem_req=0.
  - On rvalid with kill=1: discard data, kill<=0, go REQ.
  - On rvalid with kill=0: go REQ. The data goes to the output entry if the output is free or consumed this edge. Otherwise it goes to the skid entry.
- Consumption: at an edge with stall_f=0 and ValidF=1, the output is consumed.
  - Refill priority: skid entry first, then the arriving response; otherwise ValidF<=0.
  - The skid entry is written only when ValidF=1 and stall_f=1.
- Redirect (priority over stall, gnt and rvalid):
  - pc_reg<=redirect_pc_e & ~3; ValidF<=0; skid invalid.
  - In WAIT, or in REQ with gnt the same cycle: kill<=1 and go/stay WAIT, so the response is dropped.
  - In WAIT with rvalid the same cycle: the data is dropped, kill stays 0, go REQ.
- When ValidF=0, InstrF=NOP_INSTR and PCF holds its last value.
- imem_addr may change while imem_req=1 and gnt=0, but only on redirect.

## Timing
- Reset values:
  - FSM=REQ, pc_reg=RESET_PC, kill=0, skid invalid.
  - PCF=0, InstrF=NOP_INSTR, ValidF=0, PCPlus4F=4.
  - imem_req=0 while reset is high; imem_addr=RESET_PC.
- Cycle 0 is the first cycle with reset low: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - First ValidF=1 in cycle 2.
  - Throughput is one instruction per 2 cycles.
- Latency from rvalid to ValidF: 1 edge (if the output is free).
- Latency from redirect to the first request at the target: the next cycle, if REQ and not killed. Otherwise the cycle after the killed rvalid.
- Reset asserted mid-operation forces all reset values immediately. An rvalid arriving after reset is released is ignored (FSM=REQ).
- imem_req=1 with gnt=0 holds imem_addr stable cycle to cycle (absent redirect).

## Test plan
- Reset then zero-wait memory returning rdata=addr^32'hA5A5_0000 -> ValidF pulses every 2 cycles. PCF=0,4,8,C with matching InstrF. InstrF=0x13 whenever ValidF=0.
- stall_f high 5 cycles starting when ValidF=1 with a request in WAIT -> response captured in skid, imem_req=0 during the stall. After release, PCF order is 8,C then 10; no loss, no duplicate.
- redirect_e with redirect_pc_e=0x103 while WAIT on 0x8 -> rvalid for 0x8 is dropped. The next request has imem_addr=0x100, and the next valid PCF=0x100.
- Redirect with ValidF=1, stall_f=1 and skid full -> ValidF=0 the next cycle, skid empty, next fetch at the target 0x200.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> imem_addr stable through the wait, PCF sequence correct, ValidF spacing 6 cycles.
- Async reset asserted in WAIT, then an rvalid after release -> outputs at reset values during reset, the late rvalid is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding imem req/gnt/rvalid fetch, one-entry skid.
// Latency: rvalid to ValidF one edge; zero-wait memory gives one instruction per two cycles.
// Backpressure: stall_f holds the presented entry; a late response parks in the skid and blocks new requests.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state, state_nxt;
    logic        kill, kill_nxt;
    logic [31:0] pc_reg, fetch_pc;
    entry_t      out_ent, skid_ent, resp_ent;
    logic        out_vld, skid_vld;
    logic        gnt_taken, accept, consume;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        imem_req  = 1'b0;
        gnt_taken = 1'b0;
        accept    = 1'b0;
        if (state == S_REQ) begin
            imem_req  = !reset && !skid_vld && (!out_vld || !stall_f);
            gnt_taken = imem_req && imem_gnt;
            if (gnt_taken) begin
                state_nxt = S_WAIT;
                // a redirect racing the grant leaves a stale response to drop
                kill_nxt  = redirect_e;
            end
        end else begin
            if (imem_rvalid) begin
                state_nxt = S_REQ;
                kill_nxt  = 1'b0;
                accept    = !kill && !redirect_e;
            end else if (redirect_e) begin
                kill_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg   <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            if (gnt_taken)
                fetch_pc <= pc_reg;
            if (redirect_e)
                pc_reg <= redirect_pc_e & ~32'h3;
            else if (gnt_taken)
                pc_reg <= pc_reg + 32'd4;
        end
    end

    assign resp_ent = '{pc: fetch_pc, instr: imem_rdata};
    assign consume  = out_vld && !stall_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ent  <= '{pc: 32'h0, instr: NOP_INSTR};
            out_vld  <= 1'b0;
            skid_ent <= '{pc: 32'h0, instr: NOP_INSTR};
            skid_vld <= 1'b0;
        end else if (redirect_e) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (consume) begin
            if (skid_vld) begin
                out_ent  <= skid_ent;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_ent <= resp_ent;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (!out_vld) begin
            if (accept) begin
                out_ent <= resp_ent;
                out_vld <= 1'b1;
            end
        end else if (accept) begin
            skid_ent <= resp_ent;
            skid_vld <= 1'b1;
        end
    end

    assign imem_addr = pc_reg;
    assign ValidF    = out_vld;
    assign PCF       = out_ent.pc;
    assign InstrF    = out_vld ? out_ent.instr : NOP_INSTR;
    assign PCPlus4F  = out_ent.pc + 32'd4;

endmodule
